// File: rtl/fetch_unit.sv
// fetch_unit: WISC instruction fetch front end with PC/EPC, imem req/ack and a one-entry instruction buffer
//   clk, rst                   : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata    : instruction memory handshake (request held until ack)
//   instr, opCode, func        : buffered instruction and its decode fields
//   instr_pc, pc_plus2         : address of buffered instruction and its successor
//   instr_valid, instr_ready   : decoder handshake; dec_halt/siic/rti qualify an accept
//   redirect_en, redirect_pc   : execute-stage branch/jump redirect
//   halted, err                : fetch stopped; sticky misaligned-redirect flag
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(2)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [4:0]      opCode,
    output logic [1:0]      func,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            dec_halt,
    input  logic            dec_siic,
    input  logic            dec_rti,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic            err
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] VALID  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, epc_q, epc_d, req_addr_q, req_addr_d, instr_pc_q, instr_pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            squash_q, squash_d, err_q, err_d;
    logic            accept, redir;

    assign imem_req    = state_q == FETCH;
    assign imem_addr   = req_addr_q;
    assign instr_valid = state_q == VALID;
    assign halted      = state_q == HALTED;
    assign instr       = instr_q;
    assign opCode      = instr_q[15:11];
    assign func        = instr_q[1:0];
    assign instr_pc    = instr_pc_q;
    assign pc_plus2    = instr_pc_q + PC_W'(2);
    assign err         = err_q;
    assign accept      = instr_valid & instr_ready;
    assign redir       = redirect_en & ~halted;

    always_comb begin
        state_d    = state_q;
        pc_d       = redir ? {redirect_pc[PC_W-1:1], 1'b0} : pc_q;
        err_d      = err_q | (redir & redirect_pc[0]);
        epc_d      = epc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        squash_d   = squash_q;
        if (state_q == FETCH) begin
            if (imem_ack && (squash_q || redirect_en)) begin
                // stale data: drop it and restart at the (possibly redirected) pc
                squash_d   = 1'b0;
                req_addr_d = pc_d;
            end else if (imem_ack) begin
                instr_d    = imem_rdata;
                instr_pc_d = req_addr_q;
                pc_d       = req_addr_q + PC_W'(2);
                state_d    = VALID;
            end else if (redirect_en) begin
                // memory cannot cancel: keep the request, discard its data on ack
                squash_d = 1'b1;
            end
        end else if (state_q == VALID) begin
            if (redirect_en) begin
                state_d    = FETCH;
                req_addr_d = pc_d;
            end else if (accept && dec_halt) begin
                state_d = HALTED;
            end else if (accept) begin
                state_d = FETCH;
                if (dec_siic) begin
                    epc_d = pc_plus2;
                    pc_d  = EXC_VEC;
                end else if (dec_rti) begin
                    pc_d = epc_q;
                end
                req_addr_d = pc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            req_addr_q <= RESET_PC;
            instr_q    <= 16'h0800;
            instr_pc_q <= RESET_PC;
            squash_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            squash_q   <= squash_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr, imem_rdata = '0;
    logic [15:0] instr, instr_pc, pc_plus2, redirect_pc = '0;
    logic [4:0]  opCode;
    logic [1:0]  func;
    logic        instr_valid, instr_ready = 1'b0;
    logic        dec_halt = 1'b0, dec_siic = 1'b0, dec_rti = 1'b0, redirect_en = 1'b0;
    logic        halted, err;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opCode(opCode),
        .func(func), .instr_pc(instr_pc), .pc_plus2(pc_plus2), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .dec_halt(dec_halt), .dec_siic(dec_siic), .dec_rti(dec_rti),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halted(halted), .err(err)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h4123 : (16'h8000 ^ a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_word();
        imem_rdata = mem_word(imem_addr);
        imem_ack   = 1'b1;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic accept(input logic h, input logic s, input logic r);
        instr_ready = 1'b1;
        dec_halt = h; dec_siic = s; dec_rti = r;
        step();
        instr_ready = 1'b0;
        dec_halt = 1'b0; dec_siic = 1'b0; dec_rti = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] t);
        redirect_en = 1'b1;
        redirect_pc = t;
        step();
        redirect_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL reset_instr got %h exp 0800", instr); end
        n_cmp++; if ({halted, err} !== 2'b00) begin n_bad++; $display("FAIL reset_halt_err got %b exp 00", {halted, err}); end
        rst = 1'b0;
        step();
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL reset_req got %b/%h exp 1/0000", imem_req, imem_addr); end
    endtask

    task automatic test_first_fetch();
        ack_word();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ff_valid got %b exp 1", instr_valid); end
        n_cmp++; if ({opCode, func} !== {5'b01000, 2'b11}) begin n_bad++; $display("FAIL ff_decode got %b/%b exp 01000/11", opCode, func); end
        n_cmp++; if ({instr_pc, pc_plus2} !== {16'h0000, 16'h0002}) begin n_bad++; $display("FAIL ff_pc got %h/%h exp 0000/0002", instr_pc, pc_plus2); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL ff_req got %b exp 0", imem_req); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if ({instr, imem_req, instr_valid} !== {16'h4123, 1'b0, 1'b1}) begin n_bad++; $display("FAIL stall_%0d got %h/%b/%b exp 4123/0/1", i, instr, imem_req, instr_valid); end
        end
        accept(0, 0, 0);
        n_cmp++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0002, 1'b0}) begin n_bad++; $display("FAIL stall_next got %b/%h/%b exp 1/0002/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_redirect_squash();
        ack_word();
        n_cmp++; if ({instr, instr_pc} !== {16'h8002, 16'h0002}) begin n_bad++; $display("FAIL seq_instr got %h/%h exp 8002/0002", instr, instr_pc); end
        accept(0, 0, 0);
        redirect(16'h0040);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin n_bad++; $display("FAIL sq_hold got %b/%h exp 1/0004", imem_req, imem_addr); end
        step();
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin n_bad++; $display("FAIL sq_hold2 got %b/%h exp 1/0004", imem_req, imem_addr); end
        ack_word();
        n_cmp++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin n_bad++; $display("FAIL sq_drop got %b/%b/%h exp 0/1/0040", instr_valid, imem_req, imem_addr); end
        ack_word();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h8040, 16'h0040}) begin n_bad++; $display("FAIL sq_new got %b/%h/%h exp 1/8040/0040", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_siic_rti();
        redirect(16'h0010);
        n_cmp++; if ({instr_valid, imem_addr} !== {1'b0, 16'h0010}) begin n_bad++; $display("FAIL siic_redir got %b/%h exp 0/0010", instr_valid, imem_addr); end
        ack_word();
        n_cmp++; if ({instr_pc, pc_plus2} !== {16'h0010, 16'h0012}) begin n_bad++; $display("FAIL siic_pc got %h/%h exp 0010/0012", instr_pc, pc_plus2); end
        accept(0, 1, 0);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin n_bad++; $display("FAIL siic_vec got %b/%h exp 1/0002", imem_req, imem_addr); end
        ack_word();
        accept(0, 0, 1);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 16'h0012}) begin n_bad++; $display("FAIL rti_epc got %b/%h exp 1/0012", imem_req, imem_addr); end
    endtask

    task automatic test_halt();
        ack_word();
        accept(1, 0, 0);
        n_cmp++; if ({halted, imem_req, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL halt got %b/%b/%b exp 1/0/0", halted, imem_req, instr_valid); end
        redirect(16'h0050);
        step(); step();
        n_cmp++; if ({halted, imem_req} !== {1'b1, 1'b0}) begin n_bad++; $display("FAIL halt_redir got %b/%b exp 1/0", halted, imem_req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_cmp++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL halt_rst got %b/%b/%h exp 0/1/0000", halted, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_priority();
        ack_word();
        instr_ready = 1'b1; dec_halt = 1'b1;
        redirect(16'h0080);
        instr_ready = 1'b0; dec_halt = 1'b0;
        n_cmp++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0080}) begin n_bad++; $display("FAIL prio got %b/%b/%h exp 0/1/0080", halted, imem_req, imem_addr); end
        ack_word();
        n_cmp++; if ({instr_valid, instr_pc, err} !== {1'b1, 16'h0080, 1'b0}) begin n_bad++; $display("FAIL prio_fetch got %b/%h/%b exp 1/0080/0", instr_valid, instr_pc, err); end
    endtask

    task automatic test_misaligned_wrap();
        redirect(16'h0031);
        n_cmp++; if ({imem_addr, err} !== {16'h0030, 1'b1}) begin n_bad++; $display("FAIL mis got %h/%b exp 0030/1", imem_addr, err); end
        ack_word();
        accept(0, 0, 0);
        n_cmp++; if ({imem_addr, err} !== {16'h0032, 1'b1}) begin n_bad++; $display("FAIL mis_sticky got %h/%b exp 0032/1", imem_addr, err); end
        ack_word();
        redirect(16'hFFFE);
        ack_word();
        n_cmp++; if ({instr_pc, pc_plus2} !== {16'hFFFE, 16'h0000}) begin n_bad++; $display("FAIL wrap_pc got %h/%h exp FFFE/0000", instr_pc, pc_plus2); end
        accept(0, 0, 0);
        n_cmp++; if ({imem_addr, err} !== {16'h0000, 1'b1}) begin n_bad++; $display("FAIL wrap_next got %h/%b exp 0000/1", imem_addr, err); end
    endtask

    task automatic test_ack_with_redirect();
        imem_rdata = mem_word(imem_addr);
        imem_ack = 1'b1;
        redirect(16'h0060);
        imem_ack = 1'b0;
        n_cmp++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0060}) begin n_bad++; $display("FAIL ackredir got %b/%b/%h exp 0/1/0060", instr_valid, imem_req, imem_addr); end
        ack_word();
        n_cmp++; if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h8060, 16'h0060}) begin n_bad++; $display("FAIL ackredir_next got %b/%h/%h exp 1/8060/0060", instr_valid, instr, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_squash();
        test_siic_rti();
        test_halt();
        test_redirect_priority();
        test_misaligned_wrap();
        test_ack_with_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
